tod_counter: RTL and testbench
==============================

# tod_counter

Parametrised time-of-day counter that succeeds the fixed 4-cycle hour/minute/second counter in the clock display path. Adds:
- a configurable tick prescaler;
- explicit field selection for set mode, with increment and decrement;
- direct preset load with range checking;
- 12/24-hour display mode with PM flag;
- a single-cycle day-carry pulse for the date block.

Outputs feed the display module; `cout_day` feeds the date counter.

## Interface
Parameters:
- `TICK_DIV`, default 4: `clk` cycles per second, ≥1. Prescaler width is `$clog2(TICK_DIV)`, minimum 1.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `set_time_en` in 1: set mode (level) from the control state machine.
- `set_time_shift` in 1: one-cycle pulse; advances the selected field.
- `set_time_add` in 1: one-cycle pulse; increments the selected field.
- `set_time_sub` in 1: one-cycle pulse; decrements the selected field.
- `load_en` in 1: one-cycle pulse; preset the time.
- `load_hour` in 8: preset hour, binary 0–23.
- `load_minute` in 8: preset minute, binary 0–59.
- `load_second` in 8: preset second, binary 0–59.
- `mode_12h` in 1: 1 = 12-hour display, 0 = 24-hour.
- `blink1` out 2: selected field (0 none, 1 hour, 2 minute, 3 second).
- `out_hour` out 8: display hour.
- `out_minute` out 8: minute.
- `out_second` out 8: second.
- `out_pm` out 1: 1 when internal hour ≥ 12; valid in both modes.
- `cout_day` out 1: one-cycle pulse on 23:59:59 → 00:00:00.
- `load_err` out 1: one-cycle pulse when a load is rejected.

## Operation
- **Internal state.** Hour, minute, second are held in binary, always 24-hour. Also held: prescaler, `sel` register, `cout_day` register, `load_err` register.
- **Reset values.**
  - Time 00:00:00; prescaler 0; `sel` = hour.
  - All outputs: `blink1`=0, `out_hour`=0 (or 12 in 12-hour mode), `out_minute`=0, `out_second`=0, `out_pm`=0, `cout_day`=0, `load_err`=0.
- **Run mode** (`set_time_en`=0).
  - Prescaler counts 0..TICK_DIV-1.
  - On the cycle it equals TICK_DIV-1, it returns to 0 and the second advances.
  - Seconds roll 59→0 and carry to minute. Minutes roll 59→0 and carry to hour. Hour rolls 23→0 and asserts `cout_day` for exactly that one cycle.
- **Set mode** (`set_time_en`=1).
  - Time is frozen. Prescaler is held at 0.
  - The rising edge of `set_time_en` forces `sel` = hour.
  - `set_time_shift` steps `sel`: hour→minute→second→hour.
  - `set_time_add` on hour/minute: +1 with wrap (23→0, 59→0). No carry into other fields, no `cout_day`.
  - `set_time_sub` on hour/minute: −1 with wrap (0→23, 0→59).
  - Add or sub on second: clears second to 0.
  - Add and sub in the same cycle: both ignored.
  - Shift together with add/sub: the edit applies to the old `sel`; the new `sel` takes effect next cycle.
- **Load.**
  - `load_en` with all fields in range: writes hour/minute/second and clears the prescaler. Accepted in either mode.
  - Any field out of range: state unchanged; `load_err` pulses for one cycle.
- **Priority, highest first:** load > set-mode edit > run-mode tick.
- **`blink1`.** Equals `sel` encoding while `set_time_en`=1, else 0.
- **12-hour display** (`mode_12h`=1): internal 0→12, 1–12→same, 13–23→hour−12.

## Timing
- All state updates occur on the rising edge of `clk`.
- Outputs are driven from state registers. 12-hour and BCD conversion is combinational, adding no register latency.
- The first second increment after reset occurs on the TICK_DIV-th rising edge after `rst_n` deasserts.
- On exiting set mode, the next second increment occurs TICK_DIV edges later.
- An edit or load is visible on outputs the cycle after the input pulse.
- `blink1` updates the cycle after `set_time_en` or `set_time_shift` changes.
- `cout_day` and `load_err` last exactly one `clk` cycle.
- Reset asserted mid-operation clears everything immediately and asynchronously. No pulse is emitted.

## Configuration
- **`TOD_BCD_OUT_EN` defined:** `out_hour`, `out_minute`, `out_second` are packed BCD (tens in [7:4], units in [3:0]). Example: 23 → 8'h23. The 12-hour conversion is applied before BCD. `load_*` inputs remain binary.
- **Not defined:** outputs are plain binary.

## Test plan
Tests use TICK_DIV=4.
- **Reset and tick.** Release reset, run 4 edges → `out_second`=1. Run 236 further edges → second 0, minute 1.
- **Day rollover.** Load 23:59:59, run 4 edges → 00:00:00. `cout_day`=1 for one cycle only, then 0.
- **Set mode navigation.**
  - Raise `set_time_en` → `blink1`=1.
  - Sub at hour 0 → 23.
  - Shift → `blink1`=2; add at 59 → 0, hour unchanged.
  - Shift → `blink1`=3; add → second 0.
  - Shift → `blink1`=1.
  - Drop `set_time_en` → `blink1`=0; second advances 4 edges later.
- **Load checks.**
  - `load_en` with 12:60:00 → time unchanged, `load_err` pulses.
  - 12:30:45 → accepted; same-cycle add ignored (load wins).
- **12-hour mode.** Internal 00, 12, 13 → `out_hour` 12, 12, 1 and `out_pm` 0, 1, 1. With `TOD_BCD_OUT_EN` and 24-hour mode, 23:59:59 displays 8'h23/8'h59/8'h59.
- **Mid-operation reset.** Assert `rst_n`=0 during set mode at 10:20:30 → immediate 00:00:00, `blink1`=0, no `cout_day`.

Source files
------------

// File: rtl/tod_counter.sv
// Time-of-day counter: binary 24-hour state, prescaled tick, set-mode field editing, range-checked preset load,
// 12/24-hour display with PM flag and a day-carry pulse. Define TOD_BCD_OUT_EN for packed-BCD time outputs.
module tod_counter #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_time_en,
    input  logic       set_time_shift,
    input  logic       set_time_add,
    input  logic       set_time_sub,
    input  logic       load_en,
    input  logic [7:0] load_hour,
    input  logic [7:0] load_minute,
    input  logic [7:0] load_second,
    input  logic       mode_12h,
    output logic [1:0] blink1,
    output logic [7:0] out_hour,
    output logic [7:0] out_minute,
    output logic [7:0] out_second,
    output logic       out_pm,
    output logic       cout_day,
    output logic       load_err
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_HOUR = 2'd1,
        SEL_MIN  = 2'd2,
        SEL_SEC  = 2'd3
    } sel_t;

    logic [4:0]    hour_q, hour_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic [PW-1:0] pre_q, pre_d;
    sel_t          sel_q, sel_d, edit_sel;
    logic          set_q;
    logic          cday_q, cday_d;
    logic          err_q, err_d;

    logic set_rise, load_ok, edit_go, tick;
    logic [4:0] disp_hour;

    assign set_rise = set_time_en & ~set_q;
    // an edit arriving with the set-mode entry edge targets the hour field
    assign edit_sel = set_rise ? SEL_HOUR : sel_q;
    assign load_ok  = (load_hour < 8'd24) && (load_minute < 8'd60) && (load_second < 8'd60);
    assign edit_go  = set_time_add ^ set_time_sub;
    assign tick     = (pre_q == PRE_MAX);

    always_comb begin
        sel_d = sel_q;
        if (set_rise)
            sel_d = SEL_HOUR;
        else if (set_time_en && set_time_shift) begin
            case (sel_q)
                SEL_HOUR: sel_d = SEL_MIN;
                SEL_MIN:  sel_d = SEL_SEC;
                default:  sel_d = SEL_HOUR;
            endcase
        end
    end

    always_comb begin
        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        pre_d  = pre_q;
        cday_d = 1'b0;
        err_d  = 1'b0;
        if (load_en) begin
            // a rejected load freezes the whole time state for that cycle
            if (load_ok) begin
                hour_d = load_hour[4:0];
                min_d  = load_minute[5:0];
                sec_d  = load_second[5:0];
                pre_d  = '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (set_time_en) begin
            pre_d = '0;
            if (edit_go) begin
                case (edit_sel)
                    SEL_HOUR: begin
                        if (set_time_add) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                        else              hour_d = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
                    end
                    SEL_MIN: begin
                        if (set_time_add) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                        else              min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
                    end
                    default: sec_d = 6'd0;
                endcase
            end
        end else if (tick) begin
            pre_d = '0;
            if (sec_q != 6'd59) begin
                sec_d = sec_q + 6'd1;
            end else begin
                sec_d = 6'd0;
                if (min_q != 6'd59) begin
                    min_d = min_q + 6'd1;
                end else begin
                    min_d = 6'd0;
                    if (hour_q != 5'd23) begin
                        hour_d = hour_q + 5'd1;
                    end else begin
                        hour_d = 5'd0;
                        cday_d = 1'b1;
                    end
                end
            end
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hour_q <= '0;
            min_q  <= '0;
            sec_q  <= '0;
            pre_q  <= '0;
            sel_q  <= SEL_HOUR;
            set_q  <= 1'b0;
            cday_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            hour_q <= hour_d;
            min_q  <= min_d;
            sec_q  <= sec_d;
            pre_q  <= pre_d;
            sel_q  <= sel_d;
            set_q  <= set_time_en;
            cday_q <= cday_d;
            err_q  <= err_d;
        end
    end

    function automatic logic [7:0] to_out(input logic [5:0] v);
`ifdef TOD_BCD_OUT_EN
        return {4'(v / 6'd10), 4'(v % 6'd10)};
`else
        return {2'b00, v};
`endif
    endfunction

    always_comb begin
        disp_hour = hour_q;
        if (mode_12h) begin
            if (hour_q == 5'd0)       disp_hour = 5'd12;
            else if (hour_q > 5'd12)  disp_hour = hour_q - 5'd12;
        end
    end

    assign blink1     = set_q ? sel_q : SEL_NONE;
    assign out_hour   = to_out({1'b0, disp_hour});
    assign out_minute = to_out(min_q);
    assign out_second = to_out(sec_q);
    assign out_pm     = (hour_q >= 5'd12);
    assign cout_day   = cday_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_tod_counter.sv
// Scoreboard bench for tod_counter: a seconds-of-day reference model feeds an expectation queue,
// a negedge monitor pops and compares every cycle. Directed test-plan sequences, then random traffic.
module tb_tod_counter;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       set_time_en = 1'b0, set_time_shift = 1'b0, set_time_add = 1'b0, set_time_sub = 1'b0;
    logic       load_en = 1'b0;
    logic [7:0] load_hour = '0, load_minute = '0, load_second = '0;
    logic       mode_12h = 1'b0;
    logic [1:0] blink1;
    logic [7:0] out_hour, out_minute, out_second;
    logic       out_pm, cout_day, load_err;

    tod_counter #(.TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .rst_n(rst_n),
        .set_time_en(set_time_en), .set_time_shift(set_time_shift),
        .set_time_add(set_time_add), .set_time_sub(set_time_sub),
        .load_en(load_en), .load_hour(load_hour), .load_minute(load_minute), .load_second(load_second),
        .mode_12h(mode_12h),
        .blink1(blink1), .out_hour(out_hour), .out_minute(out_minute), .out_second(out_second),
        .out_pm(out_pm), .cout_day(cout_day), .load_err(load_err)
    );

    always begin
        #5 clk = 1'b1;
        #5 clk = 1'b0;
    end

    typedef struct {
        int h; int m; int s; int blink; int cday; int err;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // reference model: time of day as seconds since midnight
    int m_tod, m_cnt, m_sel, m_prev, m_cday, m_err;

    function void model_reset();
        m_tod = 0; m_cnt = 0; m_sel = 0; m_prev = 0; m_cday = 0; m_err = 0;
    endfunction

    function exp_t snap();
        exp_t e;
        e.h = m_tod / 3600;
        e.m = (m_tod / 60) % 60;
        e.s = m_tod % 60;
        e.blink = m_prev ? m_sel + 1 : 0;
        e.cday = m_cday;
        e.err = m_err;
        return e;
    endfunction

    function void model_step();
        int h, mi, s, es;
        bit rise;
        if (!rst_n) begin
            model_reset();
            return;
        end
        h = m_tod / 3600; mi = (m_tod / 60) % 60; s = m_tod % 60;
        rise = set_time_en && !m_prev;
        es = rise ? 0 : m_sel;
        m_cday = 0; m_err = 0;
        if (load_en) begin
            if (load_hour < 24 && load_minute < 60 && load_second < 60) begin
                m_tod = load_hour * 3600 + load_minute * 60 + load_second;
                m_cnt = 0;
            end else m_err = 1;
        end else if (set_time_en) begin
            m_cnt = 0;
            if (set_time_add != set_time_sub) begin
                if (es == 0)      h = (h + (set_time_add ? 1 : 23)) % 24;
                else if (es == 1) mi = (mi + (set_time_add ? 1 : 59)) % 60;
                else              s = 0;
                m_tod = h * 3600 + mi * 60 + s;
            end
        end else if (m_cnt == TICK_DIV - 1) begin
            m_cnt = 0;
            m_tod = m_tod + 1;
            if (m_tod == 86400) begin
                m_tod = 0;
                m_cday = 1;
            end
        end else m_cnt = m_cnt + 1;
        if (rise) m_sel = 0;
        else if (set_time_en && set_time_shift) m_sel = (m_sel + 1) % 3;
        m_prev = set_time_en;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
        set_time_shift = 1'b0; set_time_add = 1'b0; set_time_sub = 1'b0; load_en = 1'b0;
        q.push_back(snap());
    endtask

    task automatic load(input int h, input int m, input int s);
        load_en = 1'b1; load_hour = 8'(h); load_minute = 8'(m); load_second = 8'(s);
    endtask

    // async reset in the middle of a cycle: the pending expectation is replaced by the reset state
    task automatic hard_reset();
        rst_n = 1'b0;
        model_reset();
        q.delete();
        q.push_back(snap());
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function int fmt(input int v);
`ifdef TOD_BCD_OUT_EN
        return (v / 10) * 16 + (v % 10);
`else
        return v;
`endif
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            int dh;
            e = q.pop_front();
            dh = e.h;
            if (mode_12h) dh = (e.h == 0) ? 12 : ((e.h > 12) ? e.h - 12 : e.h);
            chk("out_hour", int'(out_hour), fmt(dh));
            chk("out_minute", int'(out_minute), fmt(e.m));
            chk("out_second", int'(out_second), fmt(e.s));
            chk("out_pm", int'(out_pm), (e.h >= 12) ? 1 : 0);
            chk("blink1", int'(blink1), e.blink);
            chk("cout_day", int'(cout_day), e.cday);
            chk("load_err", int'(load_err), e.err);
        end
    end

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        repeat (4) tick();
        repeat (236) tick();

        load(23, 59, 59); tick();
        repeat (6) tick();

        load(0, 59, 30); tick();
        set_time_en = 1'b1; tick(); tick();
        set_time_sub = 1'b1; tick(); tick();
        set_time_shift = 1'b1; tick();
        set_time_add = 1'b1; tick();
        set_time_shift = 1'b1; tick();
        set_time_add = 1'b1; tick();
        set_time_shift = 1'b1; tick(); tick();
        set_time_add = 1'b1; set_time_sub = 1'b1; tick();
        set_time_en = 1'b0; repeat (6) tick();

        load(12, 60, 0); tick(); tick();
        load(24, 0, 0); tick(); tick();
        set_time_en = 1'b1; tick();
        load(12, 30, 45); set_time_add = 1'b1; tick(); tick();
        set_time_en = 1'b0; tick();

        mode_12h = 1'b1;
        load(0, 0, 0); tick();
        load(12, 0, 0); tick();
        load(13, 0, 0); tick(); tick();
        mode_12h = 1'b0;
        load(23, 59, 59); tick(); tick();

        load(10, 20, 30); tick();
        set_time_en = 1'b1; tick();
        set_time_shift = 1'b1; tick(); tick();
        #1 hard_reset();
        set_time_en = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        repeat (5) tick();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) set_time_en = !set_time_en;
            if ($urandom_range(0, 99) == 0) mode_12h = !mode_12h;
            set_time_shift = ($urandom_range(0, 7) == 0);
            set_time_add = ($urandom_range(0, 5) == 0);
            set_time_sub = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 29) == 0) begin
                if ($urandom_range(0, 1) == 1) load(23, 59, int'($urandom_range(50, 59)));
                else load(int'($urandom_range(0, 27)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
            end
            tick();
        end

        repeat (2) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
